mul_sequencer: RTL and testbench
================================

MUL_SEQUENCER -- requirements
Module: mul_sequencer

Interface
REQ-001 Parameter ADDR_W, default 8: width of the RAM write address.
REQ-002 Clock  input  1  system clock; all state updates on rising edge.
REQ-003 Reset  input  1  asynchronous, active-low reset; all registers clear immediately on assertion (low).
REQ-004 iStart  input  1  request a multiply; sampled only in IDLE.
REQ-005 iAbort  input  1  cancel the operation in progress; returns to IDLE on the next edge.
REQ-006 iOperandA  input  16  multiplicand, unsigned; captured on an accepted start.
REQ-007 iOperandB  input  16  multiplier, unsigned; captured on an accepted start.
REQ-008 iDestAddr  input  ADDR_W  base RAM address for the result; captured on an accepted start.
REQ-009 oBusy  output  1  high in every state except IDLE.
REQ-010 oDone  output  1  one-cycle pulse when the final result write completes.
REQ-011 oWriteEnable  output  1  RAM write strobe.
REQ-012 oWriteAddress  output  ADDR_W  RAM write address.
REQ-013 oDataOut  output  16  RAM write data.
REQ-014 oProduct  output  32  full product; holds its value until the next accepted start.

Function
REQ-015 FSM states SHALL be IDLE, ACCUM, WRITE and DONE.
REQ-016 IDLE SHALL transition to ACCUM when iStart=1 and iAbort=0 (accepted start); on that edge A, B and iDestAddr are captured and the accumulator and counters clear.
REQ-017 ACCUM SHALL last exactly 8 cycles, consuming B in radix-4 order, 2 LSBs first; each cycle adds {0, A, 2A, 3A}[B pair] shifted left by 2k (k = 0..7).
REQ-018 Arithmetic SHALL be unsigned, with a 32-bit accumulator; the final value is exactly A*B with no overflow.
REQ-019 WRITE SHALL assert oWriteEnable for 4 consecutive cycles, k = 0..3: oWriteAddress = base+k (modulo 2^ADDR_W, wraps), oDataOut = {8'h00, product byte k}, LSB first.
REQ-020 oProduct SHALL update on the edge leaving ACCUM.
REQ-021 DONE SHALL last 1 cycle with oDone=1 and oWriteEnable=0, then go to IDLE.
REQ-022 Timing: start accepted at edge 0 -> ACCUM cycles 1-8, WRITE cycles 9-12, DONE cycle 13, IDLE cycle 14; a new start is acceptable at edge 14.
REQ-023 iStart outside IDLE SHALL be ignored; there is no queueing.
REQ-024 iAbort=1 in ACCUM, WRITE or DONE SHALL force IDLE on the next edge: no further writes, no oDone, oProduct unchanged; iAbort in IDLE has no effect.
REQ-025 If iStart and iAbort are both high in IDLE, abort wins and the start is not accepted.
REQ-026 oWriteEnable SHALL never be high outside WRITE.
REQ-027 Operand inputs SHALL be don't-care after capture.

Reset
REQ-028 While Reset=0, the state SHALL be IDLE and all outputs and internal registers 0, including oProduct.
REQ-029 Reset asserted mid-operation SHALL abandon the operation immediately, with oWriteEnable dropping asynchronously; no write or oDone follows.
REQ-030 The first accepted start SHALL be possible on the first rising edge after Reset deasserts.

Configuration
REQ-031 Macro MUL_SEQUENCER_PACKED_WRITE_EN controls the write format.
REQ-032 With MUL_SEQUENCER_PACKED_WRITE_EN defined: WRITE lasts 2 cycles, writing product[15:0] then product[31:16] at base and base+1; DONE occurs at cycle 11 and IDLE at cycle 12.
REQ-033 With MUL_SEQUENCER_PACKED_WRITE_EN undefined: the 4-byte behaviour of REQ-019 and REQ-022 applies.

Verification
REQ-034 A=3, B=5, base=0x10, start -> writes (0x10,0x000F),(0x11,0),(0x12,0),(0x13,0) in cycles 9-12, oDone in cycle 13, oProduct=0x0000000F.
REQ-035 A=B=0xFFFF, base=0xFE -> writes (0xFE,0x01),(0xFF,0x00),(0x00,0xFE),(0x01,0xFF) with address wrap, oProduct=0xFFFE0001.
REQ-036 Start held high continuously, A=2, B=7 -> operations accepted at edges 0 and 14 only, each producing 0x0E at byte 0.
REQ-037 iAbort pulsed in cycle 10 of A=0x1234, B=0x5678 -> only writes k=0,1 occur, no oDone, IDLE next cycle; Reset low in cycle 4 -> all outputs 0 immediately, no writes.
REQ-038 PACKED build, A=0x1234, B=0x5678, base=0x20 -> writes (0x20,0x0060),(0x21,0x0626) (product 0x06260060), oDone in cycle 11.

Source files
------------

// File: rtl/mul_sequencer.sv
`timescale 1ns/1ps
// mul_sequencer: radix-4 shift/add multiplier (16x16 -> 32, unsigned) that
// writes its product into a narrow RAM port after the accumulation phase.
// Build option: define MUL_SEQUENCER_PACKED_WRITE_EN to write the product as
// two 16-bit halfwords instead of four zero-extended bytes.
//
// state | meaning
// IDLE  | waiting for an accepted start (iStart=1, iAbort=0)
// ACCUM | 8 radix-4 add/shift steps, multiplier LSB pair first
// WRITE | one RAM write per cycle, lowest part of the product first
// DONE  | single-cycle oDone pulse, then back to IDLE
module mul_sequencer #(
    parameter int ADDR_W = 8
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              iStart,
    input  logic              iAbort,
    input  logic [15:0]       iOperandA,
    input  logic [15:0]       iOperandB,
    input  logic [ADDR_W-1:0] iDestAddr,
    output logic              oBusy,
    output logic              oDone,
    output logic              oWriteEnable,
    output logic [ADDR_W-1:0] oWriteAddress,
    output logic [15:0]       oDataOut,
    output logic [31:0]       oProduct
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // count is a down-counter; the terminal value 0 marks the last cycle of
    // ACCUM or WRITE. The write index is recovered as WRITE_LAST - count.
    localparam logic [2:0] ACCUM_LAST = 3'd7;
`ifdef MUL_SEQUENCER_PACKED_WRITE_EN
    localparam logic [2:0] WRITE_LAST = 3'd1;
`else
    localparam logic [2:0] WRITE_LAST = 3'd3;
`endif

    state_t            state;
    state_t            stateNext;
    logic [31:0]       mcand;
    logic [15:0]       mplier;
    logic [31:0]       accum;
    logic [31:0]       product;
    logic [ADDR_W-1:0] baseAddr;
    logic [2:0]        count;

    logic [31:0]       partial;
    logic [31:0]       accumSum;
    logic              countDone;
    logic              startOk;
    logic [2:0]        writeIdx;

    // Radix-4 partial product from the current multiplier pair; mcand is
    // already pre-shifted by 2k, so only the 0/1/2/3 multiple is formed here.
    always_comb begin
        partial = 32'd0;
        case (mplier[1:0])
            2'd0: partial = 32'd0;
            2'd1: partial = mcand;
            2'd2: partial = mcand << 1;
            2'd3: partial = mcand + (mcand << 1);
            default: partial = 32'd0;
        endcase
        accumSum  = accum + partial;
        countDone = (count == 3'd0);
        startOk   = iStart && !iAbort;
        writeIdx  = WRITE_LAST - count;
    end

    // Next-state logic; abort in any busy state returns to IDLE.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (startOk) stateNext = ACCUM;
            end
            ACCUM: begin
                if (iAbort)         stateNext = IDLE;
                else if (countDone) stateNext = WRITE;
            end
            WRITE: begin
                if (iAbort)         stateNext = IDLE;
                else if (countDone) stateNext = DONE;
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) state <= IDLE;
        else        state <= stateNext;
    end

    // Datapath: operand capture, accumulation, product latch and counter.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            mcand    <= 32'd0;
            mplier   <= 16'd0;
            accum    <= 32'd0;
            product  <= 32'd0;
            baseAddr <= '0;
            count    <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (startOk) begin
                        mcand    <= {16'd0, iOperandA};
                        mplier   <= iOperandB;
                        baseAddr <= iDestAddr;
                        accum    <= 32'd0;
                        count    <= ACCUM_LAST;
                    end
                end
                ACCUM: begin
                    if (!iAbort) begin
                        accum  <= accumSum;
                        mcand  <= mcand << 2;
                        mplier <= mplier >> 2;
                        if (countDone) begin
                            // Product only becomes visible on a completed
                            // accumulation; an abort leaves it untouched.
                            product <= accumSum;
                            count   <= WRITE_LAST;
                        end else begin
                            count <= count - 3'd1;
                        end
                    end
                end
                WRITE: begin
                    if (!countDone) count <= count - 3'd1;
                end
                default: ;
            endcase
        end
    end

    // Outputs decode from registered state so a reset drops them at once.
    always_comb begin
        oBusy         = (state != IDLE);
        oDone         = (state == DONE);
        oWriteEnable  = (state == WRITE);
        oProduct      = product;
        oWriteAddress = '0;
        oDataOut      = 16'd0;
        if (state == WRITE) begin
            oWriteAddress = baseAddr + ADDR_W'(writeIdx);
`ifdef MUL_SEQUENCER_PACKED_WRITE_EN
            oDataOut = writeIdx[0] ? product[31:16] : product[15:0];
`else
            case (writeIdx[1:0])
                2'd0: oDataOut = {8'h00, product[7:0]};
                2'd1: oDataOut = {8'h00, product[15:8]};
                2'd2: oDataOut = {8'h00, product[23:16]};
                2'd3: oDataOut = {8'h00, product[31:24]};
                default: oDataOut = 16'd0;
            endcase
`endif
        end
    end

endmodule

// File: tb/tb_mul_sequencer.sv
`timescale 1ns/1ps
// Testbench for mul_sequencer: directed vector table, random operations with
// random aborts, held-start, start+abort and asynchronous reset sequences.
module tb_mul_sequencer;

    localparam int ADDR_W = 8;
`ifdef MUL_SEQUENCER_PACKED_WRITE_EN
    localparam int NWR = 2;
`else
    localparam int NWR = 4;
`endif
    localparam int DONE_PH = 9 + NWR;
    localparam int PERIOD  = DONE_PH + 1;

    logic              Clock;
    logic              Reset;
    logic              iStart;
    logic              iAbort;
    logic [15:0]       iOperandA;
    logic [15:0]       iOperandB;
    logic [ADDR_W-1:0] iDestAddr;
    logic              oBusy;
    logic              oDone;
    logic              oWriteEnable;
    logic [ADDR_W-1:0] oWriteAddress;
    logic [15:0]       oDataOut;
    logic [31:0]       oProduct;

    int checks = 0;
    int errors = 0;
    logic [31:0] modelProduct = 32'd0;

    mul_sequencer #(.ADDR_W(ADDR_W)) dut (
        .Clock(Clock), .Reset(Reset), .iStart(iStart), .iAbort(iAbort),
        .iOperandA(iOperandA), .iOperandB(iOperandB), .iDestAddr(iDestAddr),
        .oBusy(oBusy), .oDone(oDone), .oWriteEnable(oWriteEnable),
        .oWriteAddress(oWriteAddress), .oDataOut(oDataOut), .oProduct(oProduct)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [15:0]       a;
        logic [15:0]       b;
        logic [ADDR_W-1:0] base;
        logic [31:0]       prod;
        int                abortAt;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected outputs for phase p of an operation (0 or beyond DONE = idle).
    task automatic expectPhase(input string tag, input int p, input logic [ADDR_W-1:0] base,
                               input logic [31:0] prod);
        logic expBusy, expWe, expDone;
        logic [31:0] tmp;
        logic [15:0] expData;
        logic [ADDR_W-1:0] expAddr;
        int k;
        expBusy = (p >= 1 && p <= DONE_PH);
        expWe   = (p >= 9 && p <= 8 + NWR);
        expDone = (p == DONE_PH);
        check({tag, ".busy"}, 32'(oBusy), 32'(expBusy));
        check({tag, ".we"}, 32'(oWriteEnable), 32'(expWe));
        check({tag, ".done"}, 32'(oDone), 32'(expDone));
        if (expWe) begin
            k = p - 9;
            expAddr = base + ADDR_W'(k);
`ifdef MUL_SEQUENCER_PACKED_WRITE_EN
            tmp = prod >> (16 * k);
            expData = tmp[15:0];
`else
            tmp = prod >> (8 * k);
            expData = {8'h00, tmp[7:0]};
`endif
            check({tag, ".addr"}, 32'(oWriteAddress), 32'(expAddr));
            check({tag, ".data"}, 32'(oDataOut), 32'(expData));
        end
    endtask

    task automatic zeroCheck(input string tag);
        check({tag, ".busy"}, 32'(oBusy), 32'd0);
        check({tag, ".we"}, 32'(oWriteEnable), 32'd0);
        check({tag, ".done"}, 32'(oDone), 32'd0);
        check({tag, ".addr"}, 32'(oWriteAddress), 32'd0);
        check({tag, ".data"}, 32'(oDataOut), 32'd0);
        check({tag, ".prod"}, oProduct, 32'd0);
    endtask

    // Called just after a negedge; runs one operation through its idle cycle.
    task automatic runOp(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [ADDR_W-1:0] base, input logic [31:0] expProd,
                         input int abortAt);
        logic [31:0] prodNow;
        bit completes;
        int p;
        completes = (abortAt == 0) || (abortAt >= 9);
        iStart = 1'b1; iOperandA = a; iOperandB = b; iDestAddr = base;
        @(posedge Clock);
        #1;
        iStart = 1'b0;
        iOperandA = 16'($urandom); iOperandB = 16'($urandom); iDestAddr = ADDR_W'($urandom);
        for (int c = 1; c <= PERIOD; c++) begin
            @(negedge Clock);
            p = (abortAt == 0 || c <= abortAt) ? c : 0;
            prodNow = (c >= 9 && completes) ? expProd : modelProduct;
            expectPhase($sformatf("%s.c%0d", tag, c), p, base, expProd);
            check($sformatf("%s.c%0d.prod", tag, c), oProduct, prodNow);
            iAbort = (c == abortAt);
        end
        iAbort = 1'b0;
        if (completes) modelProduct = expProd;
    endtask

    // Reset pulled low asynchronously in cycle resetAt of an operation.
    task automatic resetMidOp(input string tag, input int resetAt);
        iStart = 1'b1; iOperandA = 16'h1234; iOperandB = 16'h5678; iDestAddr = 8'h70;
        @(posedge Clock);
        #1 iStart = 1'b0;
        for (int c = 1; c <= resetAt; c++) begin
            @(negedge Clock);
            expectPhase($sformatf("%s.c%0d", tag, c), c, 8'h70, 32'h06260060);
        end
        #1 Reset = 1'b0;
        #1 zeroCheck({tag, ".async"});
        @(posedge Clock);
        #1 zeroCheck({tag, ".held"});
        @(negedge Clock);
        zeroCheck({tag, ".held2"});
        modelProduct = 32'd0;
        #1 Reset = 1'b1;
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{16'd3,    16'd5,    8'h10, 32'h0000000F, 0};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 8'hFE, 32'hFFFE0001, 0};
        vecs[2] = '{16'h1234, 16'h5678, 8'h20, 32'h06260060, 0};
        vecs[3] = '{16'h1234, 16'h5678, 8'h40, 32'h06260060, 10};
        vecs[4] = '{16'h00FF, 16'h0101, 8'h50, 32'h0000FFFF, 4};
        vecs[5] = '{16'h8000, 16'h8000, 8'h58, 32'h40000000, 8};
        vecs[6] = '{16'h00FF, 16'h00FF, 8'h60, 32'h0000FE01, DONE_PH};
        vecs[7] = '{16'h0000, 16'hABCD, 8'hFF, 32'h00000000, 0};
        vecs[8] = '{16'h0001, 16'hFFFF, 8'h03, 32'h0000FFFF, 0};

        Reset = 1'b0; iStart = 1'b0; iAbort = 1'b0;
        iOperandA = 16'd0; iOperandB = 16'd0; iDestAddr = '0;
        #2 zeroCheck("rst0");
        @(negedge Clock);
        zeroCheck("rst1");
        iStart = 1'b1;
        #1 Reset = 1'b1;

        for (int i = 0; i < 9; i++)
            runOp($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].base, vecs[i].prod,
                  vecs[i].abortAt);

        // Start held high: accepted only once per PERIOD.
        iStart = 1'b1; iOperandA = 16'd2; iOperandB = 16'd7; iDestAddr = 8'h30;
        @(posedge Clock);
        for (int c = 1; c <= 2 * PERIOD; c++) begin
            @(negedge Clock);
            expectPhase($sformatf("held.c%0d", c), c % PERIOD, 8'h30, 32'h0000000E);
            check($sformatf("held.c%0d.prod", c), oProduct,
                  (c >= 9) ? 32'h0000000E : modelProduct);
            if (c == PERIOD + 4) iStart = 1'b0;
        end
        modelProduct = 32'h0000000E;

        // Start together with abort is refused; abort alone in IDLE is inert.
        iStart = 1'b1; iAbort = 1'b1; iOperandA = 16'd9; iOperandB = 16'd9;
        @(negedge Clock);
        check("startAbort.busy", 32'(oBusy), 32'd0);
        check("startAbort.prod", oProduct, modelProduct);
        iStart = 1'b0;
        @(negedge Clock);
        check("idleAbort.busy", 32'(oBusy), 32'd0);
        iAbort = 1'b0;

        for (int i = 0; i < 20; i++) begin
            logic [15:0] a, b;
            logic [ADDR_W-1:0] base;
            int ab;
            a = 16'($urandom);
            b = 16'($urandom);
            base = ADDR_W'($urandom);
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, DONE_PH)) : 0;
            runOp($sformatf("rnd%0d", i), a, b, base, 32'(a) * 32'(b), ab);
        end

        resetMidOp("rstAccum", 4);
        resetMidOp("rstWrite", 10);
        // First start right after reset release, product must have cleared.
        runOp("postRst", 16'h1234, 16'h5678, 8'h20, 32'h06260060, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
